// File: rtl/aes_ctr_ctrl_pkg.sv
// Shared definitions for the AES-CTR controller: core geometry, request
// function codes, controller state encodings and the core request/response
// structures.
package aes_ctr_ctrl_pkg;

    // Core geometry: key length in 32-bit words and block length in words.
    localparam int Nk    = 4;
    localparam int Nb    = 4;
    localparam int KEY_W = 32 * Nk;
    localparam int BLK_W = 32 * Nb;

    // Core function codes issued by the controller.
    localparam logic [1:0] FUNC_NONE = 2'd0;
    localparam logic [1:0] FUNC_KEXP = 2'd1;
    localparam logic [1:0] FUNC_CIPH = 2'd2;

    // Controller states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEXP  = 3'd1;
    localparam logic [2:0] ST_KWAIT = 3'd2;
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_CIPH  = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_OUT   = 3'd6;

    // Request towards the AES core.
    typedef struct packed {
        logic             enable;
        logic [1:0]       func;
        logic [KEY_W-1:0] key;
        logic [BLK_W-1:0] data;
    } aes_in_type;

    // Response from the AES core.
    typedef struct packed {
        logic [BLK_W-1:0] result;
        logic             ready;
    } aes_out_type;

    // Mask selecting the low ctr_w bits of a counter block.
    function automatic logic [BLK_W-1:0] ctr_mask(input int ctr_w);
        return {BLK_W{1'b1}} >> (BLK_W - ctr_w);
    endfunction

endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// Data-path bundle of the AES-CTR controller: input block stream, output
// block stream and the AES core request/response pair. The controller uses
// the master view; the surrounding system uses the slave view.
interface aes_ctr_ctrl_if;
    import aes_ctr_ctrl_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [BLK_W-1:0] s_data;

    logic             m_valid;
    logic             m_ready;
    logic [BLK_W-1:0] m_data;

    aes_in_type       aes_req;
    aes_out_type      aes_rsp;

    modport master (
        input  s_valid, s_data, m_ready, aes_rsp,
        output s_ready, m_valid, m_data, aes_req
    );

    modport slave (
        output s_valid, s_data, m_ready, aes_rsp,
        input  s_ready, m_valid, m_data, aes_req
    );

endinterface

// File: rtl/aes_ctr_inc.sv
// Counter-block increment for CTR mode: adds one to the low CTR_W bits
// modulo 2^CTR_W, leaves the upper bits (nonce) untouched, and flags the
// case where the low bits roll over from all ones.
module aes_ctr_inc
    import aes_ctr_ctrl_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic [BLK_W-1:0] ctr,
    output logic [BLK_W-1:0] ctr_nxt,
    output logic             wrap
);

    localparam logic [BLK_W-1:0] MASK = ctr_mask(CTR_W);

    logic [BLK_W-1:0] low;
    logic [BLK_W-1:0] low_inc;

    // Masked add: the carry out of the counter field is discarded by the mask.
    always_comb begin
        low     = ctr & MASK;
        low_inc = (low + BLK_W'(1)) & MASK;
        ctr_nxt = (ctr & ~MASK) | low_inc;
        wrap    = (low == MASK);
    end

endmodule

// File: rtl/aes_ctr_ctrl.sv
// AES counter-mode controller. Loads the key into an external AES core,
// then encrypts the running counter block once per input block and XORs the
// keystream with the input. Encryption and decryption are the same
// operation, so only key expansion and forward cipher requests are issued.
// One block is in flight at a time.
module aes_ctr_ctrl
    import aes_ctr_ctrl_pkg::*;
#(
    parameter int CTR_W    = 32,
    parameter int KEXP_CYC = 2
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] iv,
    aes_ctr_ctrl_if.master   bus,
    output logic             key_valid,
    output logic             busy,
    output logic             ctr_wrap,
    output logic             load_err
);

    localparam int KW = (KEXP_CYC > 1) ? $clog2(KEXP_CYC + 1) : 1;

    logic [2:0]       st;
    logic [KEY_W-1:0] key_q;
    logic [BLK_W-1:0] ctr_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] m_data_q;
    logic             m_valid_q;
    logic             key_valid_q;
    logic             ctr_wrap_q;
    logic [KW-1:0]    kcnt_q;

    logic [BLK_W-1:0] ctr_nxt;
    logic             ctr_wrap_nxt;
    logic             load_ok;

    aes_ctr_inc #(
        .CTR_W (CTR_W)
    ) u_inc (
        .ctr     (ctr_q),
        .ctr_nxt (ctr_nxt),
        .wrap    (ctr_wrap_nxt)
    );

    // A key load is honoured only when idle, or when ready with no block
    // offered in the same cycle (the block has priority); otherwise it is
    // dropped and flagged for that cycle.
    always_comb begin
        load_ok  = key_load &&
                   ((st == ST_IDLE) || ((st == ST_READY) && !bus.s_valid));
        load_err = key_load && !load_ok;
    end

    // Output decode: handshakes and core request are driven from state and
    // registered data so nothing leaks out while reset is held.
    always_comb begin
        bus.s_ready = (st == ST_READY);
        bus.m_valid = m_valid_q;
        bus.m_data  = m_data_q;
        key_valid   = key_valid_q;
        ctr_wrap    = ctr_wrap_q;
        busy        = (st != ST_IDLE) && (st != ST_READY);

        bus.aes_req.enable = (st == ST_KEXP) || (st == ST_CIPH);
        bus.aes_req.key    = key_q;
        bus.aes_req.func   = FUNC_NONE;
        bus.aes_req.data   = '0;
        if (st == ST_KEXP) begin
            bus.aes_req.func = FUNC_KEXP;
        end else if ((st == ST_CIPH) || (st == ST_WAIT)) begin
            // The counter block stays on the bus until the core answers.
            bus.aes_req.func = FUNC_CIPH;
            bus.aes_req.data = ctr_q;
        end
    end

    // Control FSM together with the key, counter and block registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_IDLE;
            key_q       <= '0;
            ctr_q       <= '0;
            blk_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            key_valid_q <= 1'b0;
            ctr_wrap_q  <= 1'b0;
            kcnt_q      <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_READY: begin
                    if ((st == ST_READY) && bus.s_valid) begin
                        blk_q <= bus.s_data;
                        st    <= ST_CIPH;
                    end else if (load_ok) begin
                        key_q       <= key;
                        ctr_q       <= iv;
                        key_valid_q <= 1'b0;
                        ctr_wrap_q  <= 1'b0;
                        st          <= ST_KEXP;
                    end
                end
                ST_KEXP: begin
                    kcnt_q <= KW'(KEXP_CYC);
                    st     <= ST_KWAIT;
                end
                ST_KWAIT: begin
                    // Counts down KEXP_CYC cycles; the key is usable once
                    // the count reaches zero.
                    kcnt_q <= kcnt_q - KW'(1);
                    if (kcnt_q <= KW'(1)) begin
                        key_valid_q <= 1'b1;
                        st          <= ST_READY;
                    end
                end
                ST_CIPH: begin
                    st <= ST_WAIT;
                end
                ST_WAIT: begin
                    // No timeout: the core is trusted to answer eventually.
                    if (bus.aes_rsp.ready) begin
                        m_data_q  <= blk_q ^ bus.aes_rsp.result;
                        m_valid_q <= 1'b1;
                        ctr_q     <= ctr_nxt;
                        if (ctr_wrap_nxt) begin
                            ctr_wrap_q <= 1'b1;
                        end
                        st <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        st        <= ST_READY;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Directed testbench for aes_ctr_ctrl with a behavioural AES core stand-in.
// The core answers cipher requests with the NIST SP800-38A F.5.1 keystream
// for the two known counter blocks and a fixed scramble otherwise. Expected
// output blocks are queued when a block is sent and checked by a separate
// monitor whenever an output beat is accepted.
module tb_aes_ctr_ctrl;
    import aes_ctr_ctrl_pkg::*;

    localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT1   = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT2   = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] WIV   = 128'h000102030405060708090a0bffffffff;
    localparam logic [127:0] WCTR2 = 128'h000102030405060708090a0b00000000;
    localparam logic [127:0] WCTR3 = 128'h000102030405060708090a0b00000001;
    localparam logic [127:0] WCTR4 = 128'h000102030405060708090a0b00000002;
    localparam logic [127:0] WCTR5 = 128'h000102030405060708090a0b00000003;
    localparam logic [127:0] SCR   = 128'h0123456789abcdeffedcba9876543210;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key;
    logic [127:0] iv;
    logic         key_valid;
    logic         busy;
    logic         ctr_wrap;
    logic         load_err;

    logic         core_ready;
    logic [127:0] core_result;
    logic         spur_ready;
    logic [127:0] spur_result;
    int           core_lat;
    logic [127:0] last_req;
    logic [127:0] kexp_key;

    int checks;
    int failures;
    logic [127:0] exp_q[$];

    aes_ctr_ctrl_if bus ();

    assign bus.aes_rsp = {(spur_ready ? spur_result : core_result), core_ready | spur_ready};

    aes_ctr_ctrl #(
        .CTR_W    (32),
        .KEXP_CYC (2)
    ) dut (
        .rst       (rst),
        .clk       (clk),
        .key_load  (key_load),
        .key       (key),
        .iv        (iv),
        .bus       (bus),
        .key_valid (key_valid),
        .busy      (busy),
        .ctr_wrap  (ctr_wrap),
        .load_err  (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keystream produced by the core stand-in for a given counter block.
    function automatic logic [127:0] ks(input logic [127:0] c);
        if (c == IV)   return PT1 ^ CT1;
        if (c == CTR2) return PT2 ^ CT2;
        return {c[63:0], c[127:64]} ^ SCR;
    endfunction

    task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // AES core stand-in: answers a cipher request after core_lat cycles.
    initial begin
        logic         pend;
        logic [127:0] pend_data;
        int           cnt;
        pend        = 1'b0;
        pend_data   = '0;
        cnt         = 0;
        core_ready  = 1'b0;
        core_result = '0;
        last_req    = '0;
        kexp_key    = '0;
        forever begin
            @(negedge clk);
            core_ready = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        core_ready  = 1'b1;
                        core_result = ks(pend_data);
                        pend        = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (bus.aes_req.enable && bus.aes_req.func == FUNC_CIPH) begin
                    pend      = 1'b1;
                    pend_data = bus.aes_req.data;
                    last_req  = bus.aes_req.data;
                    cnt       = core_lat;
                end
                if (bus.aes_req.enable && bus.aes_req.func == FUNC_KEXP) begin
                    kexp_key = bus.aes_req.key;
                end
            end
        end
    end

    // Output monitor: every accepted output beat must match the queue head.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0h expected no output", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", {132'd0, bus.m_data}, {132'd0, e});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_key(input logic [127:0] k, input logic [127:0] v);
        @(posedge clk); #1;
        key_load = 1'b1;
        key      = k;
        iv       = v;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic wait_kv();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (key_valid) ok = 1'b1;
        end
        chk("key_valid_rise", {259'd0, key_valid}, 260'd1);
    endtask

    task automatic send_block(input logic [127:0] d, input logic [127:0] e, input bit push);
        bit ok = 1'b0;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.s_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got s_ready=0 expected 1");
        end
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.s_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [127:0] held;
        bit           seen;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        key_load    = 1'b0;
        key         = '0;
        iv          = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        spur_ready  = 1'b0;
        spur_result = '0;
        core_lat    = 2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {254'd0, bus.s_ready, bus.m_valid, key_valid, busy, ctr_wrap, load_err}, 260'd0);
        chk("reset_req", {1'b0, bus.aes_req}, 260'd0);
        chk("reset_mdata", {132'd0, bus.m_data}, 260'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // NIST F.5.1 encrypt, two blocks.
        load_key(KEY, IV);
        wait_kv();
        chk("kexp_key", {132'd0, kexp_key}, {132'd0, KEY});
        send_block(PT1, CT1, 1'b1);
        wait_drain();
        chk("req_ctr1", {132'd0, last_req}, {132'd0, IV});
        send_block(PT2, CT2, 1'b1);
        wait_drain();
        chk("req_ctr2", {132'd0, last_req}, {132'd0, CTR2});
        chk("no_wrap_nist", {259'd0, ctr_wrap}, 260'd0);

        // Decrypt symmetry after a re-key with the same key and iv.
        load_key(KEY, IV);
        @(negedge clk);
        chk("rekey_clears_kv", {259'd0, key_valid}, 260'd0);
        wait_kv();
        send_block(CT1, PT1, 1'b1);
        wait_drain();

        // Counter wrap in the low 32 bits.
        load_key(KEY, WIV);
        wait_kv();
        send_block(PT2, PT2 ^ ks(WIV), 1'b1);
        wait_drain();
        chk("wrap_set", {259'd0, ctr_wrap}, 260'd1);
        send_block(PT1, PT1 ^ ks(WCTR2), 1'b1);
        wait_drain();
        chk("wrap_req_ctr", {132'd0, last_req}, {132'd0, WCTR2});

        // Backpressure: output held while m_ready is low.
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        send_block(CT2, CT2 ^ ks(WCTR3), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen = 1'b1;
        end
        chk("bp_m_valid", {259'd0, bus.m_valid}, 260'd1);
        held = bus.m_data;
        chk("bp_data", {132'd0, held}, {132'd0, CT2 ^ ks(WCTR3)});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", {131'd0, bus.m_valid, bus.m_data}, {131'd1, held});
            chk("bp_s_ready", {259'd0, bus.s_ready}, 260'd0);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release", {258'd0, bus.s_ready, bus.m_valid}, 260'd2);

        // key_load while waiting on the core: ignored, block completes.
        core_lat = 6;
        send_block(PT1, PT1 ^ ks(WCTR4), 1'b1);
        @(posedge clk); #1;
        key_load = 1'b1;
        key      = KEY2;
        iv       = '0;
        @(negedge clk);
        chk("wait_load_err", {258'd0, load_err, busy}, 260'd3);
        @(posedge clk); #1;
        key_load = 1'b0;
        @(negedge clk);
        chk("load_err_pulse", {259'd0, load_err}, 260'd0);
        wait_drain();
        chk("wait_key_kept", {132'd0, bus.aes_req.key}, {132'd0, KEY});

        // key_load and s_valid together in READY: the block wins.
        core_lat = 2;
        exp_q.push_back(PT2 ^ ks(WCTR5));
        @(posedge clk); #1;
        bus.s_valid = 1'b1;
        bus.s_data  = PT2;
        key_load    = 1'b1;
        key         = KEY2;
        iv          = '0;
        @(negedge clk);
        chk("same_cycle_err", {258'd0, load_err, bus.s_ready}, 260'd3);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        key_load    = 1'b0;
        wait_drain();
        chk("same_cycle_ctr", {132'd0, last_req}, {132'd0, WCTR5});
        chk("same_cycle_key", {131'd0, key_valid, bus.aes_req.key}, {131'd1, KEY});

        // Spurious core response while READY.
        @(posedge clk); #1;
        spur_ready  = 1'b1;
        spur_result = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        @(posedge clk); #1;
        spur_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_no_out", {258'd0, bus.m_valid, bus.s_ready}, 260'd1);
        end

        // Reset while waiting on the core, then a late response.
        core_lat = 30;
        send_block(PT1, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wait_flags", {254'd0, bus.s_ready, bus.m_valid, key_valid, busy, ctr_wrap, load_err}, 260'd0);
        chk("rst_wait_req", {1'b0, bus.aes_req}, 260'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        spur_ready = 1'b1;
        @(posedge clk); #1;
        spur_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_rsp_no_out", {258'd0, bus.m_valid, busy}, 260'd0);
        end

        chk("queue_empty", 260'(exp_q.size()), 260'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
